// File: rtl/shift4_arb_ctrl_if.sv
// Bus bundle for shift4_arb_ctrl: two requesters' request/data inputs plus
// grant, serial-shift strobe and reassembled-word outputs.
interface shift4_arb_ctrl_if #(
    parameter int unsigned LENGTH = 4
);
    logic [1:0]        req;
    logic [LENGTH-1:0] din0;
    logic [LENGTH-1:0] din1;
    logic [1:0]        gnt;
    logic              busy;
    logic              sh_en;
    logic              sd;
    logic              done;
    logic [LENGTH-1:0] dout;
    logic              src;

    modport master (
        output req, din0, din1,
        input  gnt, busy, sh_en, sd, done, dout, src
    );

    modport slave (
        input  req, din0, din1,
        output gnt, busy, sh_en, sd, done, dout, src
    );
endinterface

// File: rtl/shift4_arb_ctrl.sv
// Two-requester arbiter that serialises the winner's word MSB first and reassembles it.
// Define SHIFT4_ARB_RR_EN for round-robin arbitration; default is fixed priority (requester 0).
module shift4_arb_ctrl #(
    parameter int unsigned LENGTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    shift4_arb_ctrl_if.slave   bus
);
    localparam int unsigned CW = $clog2(LENGTH) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [LENGTH-1:0] word_q, word_d;
    logic [LENGTH-1:0] cap_q, cap_d;
    logic              win_q, win_d;
    logic [1:0]        gnt_q, gnt_d;
    logic              busy_q, busy_d;
    logic              sh_en_q, sh_en_d;
    logic              sd_q, sd_d;
    logic              done_q, done_d;
    logic [LENGTH-1:0] dout_q, dout_d;
    logic              src_q, src_d;

    logic              arb_win;
    logic [LENGTH-1:0] din_sel;
    logic [LENGTH-1:0] bit_mask;
    logic              last_shift;

`ifdef SHIFT4_ARB_RR_EN
    logic              last_q, last_d;
`endif

    always_comb begin
`ifdef SHIFT4_ARB_RR_EN
        arb_win = (bus.req == 2'b11) ? ~last_q : bus.req[1];
`else
        arb_win = ~bus.req[0];
`endif
        din_sel    = arb_win ? bus.din1 : bus.din0;
        last_shift = (cnt_q == CW'(LENGTH - 1));
        // Selects word bit LENGTH-1-(cnt+1): the bit presented on the next shift cycle
        bit_mask   = {1'b1, {(LENGTH-1){1'b0}}} >> (cnt_q + CW'(1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            cap_q   <= '0;
            win_q   <= 1'b0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            sh_en_q <= 1'b0;
            sd_q    <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= '0;
            src_q   <= 1'b0;
`ifdef SHIFT4_ARB_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            cap_q   <= cap_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            sh_en_q <= sh_en_d;
            sd_q    <= sd_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
            src_q   <= src_d;
`ifdef SHIFT4_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        cap_d   = cap_q;
        win_d   = win_q;
`ifdef SHIFT4_ARB_RR_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    word_d  = din_sel;
                    win_d   = arb_win;
`ifdef SHIFT4_ARB_RR_EN
                    last_d  = arb_win;
`endif
                end
            end
            SHIFT: begin
                cap_d = (cap_q << 1) | LENGTH'(sd_q);
                cnt_d = cnt_q + CW'(1);
                if (last_shift) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output registers are loaded one edge ahead so every output is a flop
    always_comb begin
        gnt_d   = '0;
        sh_en_d = 1'b0;
        done_d  = 1'b0;
        busy_d  = (state_d != IDLE);
        sd_d    = sd_q;
        dout_d  = dout_q;
        src_d   = src_q;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    gnt_d[arb_win] = 1'b1;
                    sh_en_d        = 1'b1;
                    sd_d           = din_sel[LENGTH-1];
                end
            end
            SHIFT: begin
                if (last_shift) begin
                    sd_d   = 1'b0;
                    done_d = 1'b1;
                    dout_d = cap_d;
                    src_d  = win_q;
                end else begin
                    sh_en_d = 1'b1;
                    sd_d    = |(word_q & bit_mask);
                end
            end
            default: ;
        endcase
    end

    assign bus.gnt   = gnt_q;
    assign bus.busy  = busy_q;
    assign bus.sh_en = sh_en_q;
    assign bus.sd    = sd_q;
    assign bus.done  = done_q;
    assign bus.dout  = dout_q;
    assign bus.src   = src_q;
endmodule

// File: tb/tb_shift4_arb_ctrl.sv
// Directed scoreboard bench for shift4_arb_ctrl; expected contention winners follow SHIFT4_ARB_RR_EN.
module tb_shift4_arb_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;
    int   gcyc;
    int   lat;
    int   g_prev;

    typedef struct {
        logic [1:0] gnt;
        logic [3:0] word;
        logic       src;
    } exp_t;

    exp_t sb[$];

    shift4_arb_ctrl_if #(.LENGTH(4)) bus ();

    shift4_arb_ctrl #(.LENGTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // act: 0 none, 1 pulse req=10 while shifting, 2 change din0 at T+2
    task automatic observe(input bit drop, input int act);
        exp_t e;
        int   n;
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.gnt === 2'b00 && n < 20);
        if (bus.gnt === 2'b00) begin
            chk("grant_timeout", 0, 1);
            return;
        end
        lat  = n;
        gcyc = cyc;
        chk("gnt", bus.gnt, e.gnt);
        chk("busy_shift", bus.busy, 1);
        chk("sh_en_0", bus.sh_en, 1);
        chk("sd_0", bus.sd, e.word[3]);
        chk("done_shift", bus.done, 0);
        if (drop) bus.req = 2'b00;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk("gnt_pulse", bus.gnt, 0);
            chk("sh_en_n", bus.sh_en, 1);
            chk("sd_n", bus.sd, e.word[3-i]);
            if (act == 1 && i == 1) bus.req = 2'b10;
            if (act == 1 && i == 2) bus.req = 2'b00;
            if (act == 2 && i == 1) bus.din0 = 4'b0011;
        end
        @(negedge clk);
        chk("done", bus.done, 1);
        chk("dout", bus.dout, e.word);
        chk("src", bus.src, e.src);
        chk("sh_en_off", bus.sh_en, 0);
        chk("gnt_done", bus.gnt, 0);
        chk("busy_done", bus.busy, 1);
        @(negedge clk);
        chk("done_pulse", bus.done, 0);
        chk("busy_idle", bus.busy, 0);
        chk("gnt_idle", bus.gnt, 0);
        chk("dout_hold", bus.dout, e.word);
    endtask

    initial begin
        int n;
        checks   = 0;
        errors   = 0;
        rst      = 1'b0;
        bus.req  = 2'b00;
        bus.din0 = 4'b0000;
        bus.din1 = 4'b0000;
        repeat (3) @(negedge clk);
        chk("reset_outs", {bus.gnt, bus.busy, bus.sh_en, bus.sd, bus.done, bus.dout, bus.src}, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_outs", {bus.gnt, bus.busy, bus.sh_en, bus.sd, bus.done, bus.dout, bus.src}, 0);

        // contention, req=11 held across three grants
        bus.din0 = 4'b0110;
        bus.din1 = 4'b1001;
        bus.req  = 2'b11;
        sb.push_back('{gnt: 2'b01, word: 4'b0110, src: 1'b0});
`ifdef SHIFT4_ARB_RR_EN
        sb.push_back('{gnt: 2'b10, word: 4'b1001, src: 1'b1});
`else
        sb.push_back('{gnt: 2'b01, word: 4'b0110, src: 1'b0});
`endif
        sb.push_back('{gnt: 2'b01, word: 4'b0110, src: 1'b0});
        observe(0, 0);
        chk("cont_latency", lat, 1);
        g_prev = gcyc;
        observe(0, 0);
        chk("cont_spacing1", gcyc - g_prev, 6);
        g_prev = gcyc;
        observe(1, 0);
        chk("cont_spacing2", gcyc - g_prev, 6);

        // single request from requester 0
        bus.din0 = 4'b1011;
        bus.req  = 2'b01;
        sb.push_back('{gnt: 2'b01, word: 4'b1011, src: 1'b0});
        observe(1, 0);
        chk("single_latency", lat, 1);

        // request from requester 1 while busy must be dropped
        bus.din0 = 4'b1010;
        bus.req  = 2'b01;
        sb.push_back('{gnt: 2'b01, word: 4'b1010, src: 1'b0});
        observe(1, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("busy_req_ignored", {bus.gnt, bus.busy}, 0);
        end

        // din0 changes after the grant edge
        bus.din0 = 4'b1100;
        bus.req  = 2'b01;
        sb.push_back('{gnt: 2'b01, word: 4'b1100, src: 1'b0});
        observe(1, 2);

        // reset during the second shift cycle
        bus.din0 = 4'b1011;
        bus.req  = 2'b01;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.gnt === 2'b00 && n < 20);
        chk("rst_grant", bus.gnt, 2'b01);
        bus.req = 2'b00;
        @(negedge clk);
        chk("rst_sh_en_2nd", bus.sh_en, 1);
        rst = 1'b0;
        #1;
        chk("rst_async_outs", {bus.gnt, bus.busy, bus.sh_en, bus.sd, bus.done, bus.dout, bus.src}, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_no_done", bus.done, 0);
        end
        rst      = 1'b1;
        bus.din1 = 4'b0101;
        bus.req  = 2'b10;
        sb.push_back('{gnt: 2'b10, word: 4'b0101, src: 1'b1});
        observe(1, 0);
        chk("post_rst_latency", lat, 1);
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
